uart_tx_arb: RTL and testbench

UART_TX_ARB -- requirements
Module: uart_tx_arb

---
 rtl/uart_tx_arb.sv | 99 +++++++++
 tb/tb_uart_tx_arb.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arb.sv
// Round-robin arbiter that lets N_REQ byte sources share one UART transmitter,
// granting each winner up to BURST consecutive bytes before re-arbitrating.
module uart_tx_arb #(
  parameter int N_REQ = 4,
  parameter int BURST = 4,
  localparam int GW = $clog2(N_REQ),
  localparam int CW = $clog2(BURST + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N_REQ-1:0]   req_valid,
  input  logic [8*N_REQ-1:0] req_data,
  output logic [N_REQ-1:0]   req_ready,
  input  logic               tx_ready_in,
  output logic               tx_valid_out,
  output logic [7:0]         tx_data_out,
  output logic [GW-1:0]      grant_id,
  output logic               busy
);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t        state;
  logic [GW-1:0] last;
  logic [CW-1:0] cnt;
  logic [GW-1:0] next_id;
  logic [GW-1:0] cand;
  logic          found;
  logic          fire;
  logic          last_beat;
  logic [7:0]    data_arr [N_REQ];

  always_comb begin
    for (int i = 0; i < N_REQ; i++) begin
      data_arr[i] = req_data[8*i +: 8];
    end
  end

  // Search starts just past the previous holder, so a requester that just
  // finished is the last one considered on the next arbitration.
  always_comb begin
    next_id = grant_id;
    cand    = '0;
    found   = 1'b0;
    for (int k = 1; k <= N_REQ; k++) begin
      cand = GW'((int'(last) + k) % N_REQ);
      if (!found && req_valid[cand]) begin
        next_id = cand;
        found   = 1'b1;
      end
    end
  end

  always_comb begin
    tx_valid_out = 1'b0;
    tx_data_out  = 8'h00;
    req_ready    = '0;
    if (state == GRANT) begin
      tx_valid_out        = req_valid[grant_id];
      tx_data_out         = data_arr[grant_id];
      req_ready[grant_id] = tx_ready_in;
    end
  end

  assign fire      = (state == GRANT) && tx_valid_out && tx_ready_in;
  assign last_beat = (int'(cnt) + 1) == BURST;
  assign busy      = (state == GRANT);

  // A grant ends on the final byte of a burst or as soon as the holder drops
  // valid; either way one IDLE cycle separates consecutive grants.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      grant_id <= '0;
      last     <= GW'(N_REQ - 1);
      cnt      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (|req_valid) begin
            state    <= GRANT;
            grant_id <= next_id;
            cnt      <= '0;
          end
        end
        GRANT: begin
          if (!req_valid[grant_id] || (fire && last_beat)) begin
            state <= IDLE;
            last  <= grant_id;
          end else if (fire) begin
            cnt <= cnt + CW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arb.sv
// Directed-vector bench for uart_tx_arb: a BURST=4 instance for the main
// sequences and a BURST=1 instance for the round-robin rotation.
module tb_uart_tx_arb;

  logic        clk;
  logic        rst;
  logic [3:0]  req_valid;
  logic [31:0] req_data;
  logic        tx_ready_in;

  logic [3:0]  rr4, rr1;
  logic        tv4, tv1;
  logic [7:0]  td4, td1;
  logic [1:0]  g4, g1;
  logic        b4, b1;

  int n_checks = 0;
  int n_pass   = 0;

  localparam logic [31:0] D  = 32'h33A5110F;
  localparam logic [31:0] D2 = 32'h33A5120F;

  typedef struct {
    logic [3:0]  valid;
    logic [31:0] data;
    logic        txr;
    logic        e_txv;
    logic [7:0]  e_data;
    logic [3:0]  e_ready;
    logic [1:0]  e_grant;
    logic        e_busy;
  } vec_t;

  vec_t vecs [13];
  logic [7:0] port_byte [4];

  uart_tx_arb #(.N_REQ(4), .BURST(4)) u_dut4 (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
    .req_ready(rr4), .tx_ready_in(tx_ready_in), .tx_valid_out(tv4),
    .tx_data_out(td4), .grant_id(g4), .busy(b4)
  );

  uart_tx_arb #(.N_REQ(4), .BURST(1)) u_dut1 (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
    .req_ready(rr1), .tx_ready_in(tx_ready_in), .tx_valid_out(tv1),
    .tx_data_out(td1), .grant_id(g1), .busy(b1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change just after the rising edge; outputs are sampled at the falling edge.
  task automatic applyStimulus(input logic [3:0] v, input logic [31:0] d, input logic txr);
    @(posedge clk);
    #1;
    req_valid   = v;
    req_data    = d;
    tx_ready_in = txr;
    @(negedge clk);
  endtask

  task automatic checkOutput(input string name, input bit use_b1, input logic e_txv,
                             input logic [7:0] e_data, input logic [3:0] e_ready,
                             input logic [1:0] e_grant, input logic e_busy);
    logic [15:0] act, exp;
    exp = {e_txv, e_data, e_ready, e_grant, e_busy};
    act = use_b1 ? {tv1, td1, rr1, g1, b1} : {tv4, td4, rr4, g4, b4};
    n_checks++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("[TB] FAIL %s: got txv=%b data=%h ready=%b grant=%0d busy=%b, expected txv=%b data=%h ready=%b grant=%0d busy=%b",
               name, act[15], act[14:7], act[6:3], act[2:1], act[0],
               exp[15], exp[14:7], exp[6:3], exp[2:1], exp[0]);
    end
  endtask

  initial begin
    port_byte[0] = 8'h0F;
    port_byte[1] = 8'h11;
    port_byte[2] = 8'hA5;
    port_byte[3] = 8'h33;

    //            valid    data txr  txv data   ready    grant busy
    vecs[0]  = '{4'b0100, D,  1'b1, 1'b0, 8'h00, 4'b0000, 2'd0, 1'b0};
    vecs[1]  = '{4'b0100, D,  1'b1, 1'b1, 8'hA5, 4'b0100, 2'd2, 1'b1};
    vecs[2]  = '{4'b0000, D,  1'b1, 1'b0, 8'hA5, 4'b0100, 2'd2, 1'b1};
    vecs[3]  = '{4'b0000, D,  1'b1, 1'b0, 8'h00, 4'b0000, 2'd2, 1'b0};
    vecs[4]  = '{4'b0010, D,  1'b1, 1'b0, 8'h00, 4'b0000, 2'd2, 1'b0};
    vecs[5]  = '{4'b0010, D,  1'b1, 1'b1, 8'h11, 4'b0010, 2'd1, 1'b1};
    vecs[6]  = '{4'b0010, D2, 1'b1, 1'b1, 8'h12, 4'b0010, 2'd1, 1'b1};
    vecs[7]  = '{4'b0010, D,  1'b1, 1'b1, 8'h11, 4'b0010, 2'd1, 1'b1};
    vecs[8]  = '{4'b0010, D,  1'b1, 1'b1, 8'h11, 4'b0010, 2'd1, 1'b1};
    vecs[9]  = '{4'b0010, D,  1'b1, 1'b0, 8'h00, 4'b0000, 2'd1, 1'b0};
    vecs[10] = '{4'b1010, D,  1'b1, 1'b1, 8'h11, 4'b0010, 2'd1, 1'b1};
    vecs[11] = '{4'b1000, D,  1'b1, 1'b0, 8'h11, 4'b0010, 2'd1, 1'b1};
    vecs[12] = '{4'b1000, D,  1'b1, 1'b0, 8'h00, 4'b0000, 2'd1, 1'b0};

    rst         = 1'b1;
    req_valid   = 4'b1111;
    req_data    = D;
    tx_ready_in = 1'b1;
    @(negedge clk);
    @(negedge clk);
    checkOutput("reset_dut4", 1'b0, 1'b0, 8'h00, 4'b0000, 2'd0, 1'b0);
    checkOutput("reset_dut1", 1'b1, 1'b0, 8'h00, 4'b0000, 2'd0, 1'b0);

    @(posedge clk);
    #1;
    rst       = 1'b0;
    req_valid = 4'b0000;
    @(negedge clk);
    checkOutput("post_reset_idle", 1'b0, 1'b0, 8'h00, 4'b0000, 2'd0, 1'b0);

    // Single requester, burst limit, regrant and ignored late valids
    for (int i = 0; i < 13; i++) begin
      applyStimulus(vecs[i].valid, vecs[i].data, vecs[i].txr);
      checkOutput($sformatf("vec%0d", i), 1'b0, vecs[i].e_txv, vecs[i].e_data,
                  vecs[i].e_ready, vecs[i].e_grant, vecs[i].e_busy);
    end

    // Backpressure on port 3: ten stalled cycles, then a full burst of four
    for (int i = 0; i < 10; i++) begin
      applyStimulus(4'b1000, D, 1'b0);
      checkOutput($sformatf("stall%0d", i), 1'b0, 1'b1, 8'h33, 4'b0000, 2'd3, 1'b1);
    end
    for (int i = 0; i < 4; i++) begin
      applyStimulus(4'b1000, D, 1'b1);
      checkOutput($sformatf("bp_fire%0d", i), 1'b0, 1'b1, 8'h33, 4'b1000, 2'd3, 1'b1);
    end

    // Wrap-around from last=3 to port 0, then back to port 3
    applyStimulus(4'b1001, D, 1'b1);
    checkOutput("burst_end_idle", 1'b0, 1'b0, 8'h00, 4'b0000, 2'd3, 1'b0);
    applyStimulus(4'b1001, D, 1'b1);
    checkOutput("wrap_grant0", 1'b0, 1'b1, 8'h0F, 4'b0001, 2'd0, 1'b1);
    applyStimulus(4'b1000, D, 1'b1);
    checkOutput("wrap_drop0", 1'b0, 1'b0, 8'h0F, 4'b0001, 2'd0, 1'b1);
    applyStimulus(4'b1000, D, 1'b1);
    checkOutput("wrap_idle", 1'b0, 1'b0, 8'h00, 4'b0000, 2'd0, 1'b0);
    applyStimulus(4'b1000, D, 1'b1);
    checkOutput("wrap_grant3", 1'b0, 1'b1, 8'h33, 4'b1000, 2'd3, 1'b1);
    applyStimulus(4'b0000, D, 1'b1);
    checkOutput("wrap_drop3", 1'b0, 1'b0, 8'h33, 4'b1000, 2'd3, 1'b1);
    applyStimulus(4'b0000, D, 1'b1);
    checkOutput("wrap_end_idle", 1'b0, 1'b0, 8'h00, 4'b0000, 2'd3, 1'b0);

    // Reset in the middle of a port 2 burst
    applyStimulus(4'b0100, D, 1'b1);
    checkOutput("mid_idle", 1'b0, 1'b0, 8'h00, 4'b0000, 2'd3, 1'b0);
    applyStimulus(4'b0100, D, 1'b1);
    checkOutput("mid_fire1", 1'b0, 1'b1, 8'hA5, 4'b0100, 2'd2, 1'b1);
    applyStimulus(4'b0100, D, 1'b1);
    checkOutput("mid_fire2", 1'b0, 1'b1, 8'hA5, 4'b0100, 2'd2, 1'b1);
    @(posedge clk);
    #1;
    rst       = 1'b1;
    req_valid = 4'b0011;
    #1;
    checkOutput("mid_reset_immediate", 1'b0, 1'b0, 8'h00, 4'b0000, 2'd0, 1'b0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    checkOutput("mid_release_idle", 1'b0, 1'b0, 8'h00, 4'b0000, 2'd0, 1'b0);
    applyStimulus(4'b0011, D, 1'b1);
    checkOutput("mid_port0_wins", 1'b0, 1'b1, 8'h0F, 4'b0001, 2'd0, 1'b1);

    // Round-robin rotation on the BURST=1 instance, all ports valid
    @(posedge clk);
    #1;
    rst       = 1'b1;
    req_valid = 4'b0000;
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int k = 0; k < 10; k++) begin
      applyStimulus(4'b1111, D, 1'b1);
      if (k % 2 == 0) begin
        checkOutput($sformatf("rr%0d", k), 1'b1, 1'b0, 8'h00, 4'b0000,
                    (k == 0) ? 2'd0 : 2'(((k - 2) / 2) % 4), 1'b0);
      end else begin
        checkOutput($sformatf("rr%0d", k), 1'b1, 1'b1, port_byte[((k - 1) / 2) % 4],
                    4'(1 << (((k - 1) / 2) % 4)), 2'(((k - 1) / 2) % 4), 1'b1);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
